// File: rtl/eq_band_scheduler.sv
// Graphic-EQ band controller: stages per-band gains, serialises coefficient
// updates onto a shared gain bus and broadcasts the sample-advance strobe.
module eq_band_scheduler #(
  parameter int unsigned N_BANDS     = 10,
  parameter int unsigned BAND_W      = 4,
  parameter int unsigned SET_CYCLES  = 4,
  parameter int unsigned NEXT_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [BAND_W-1:0]  i_wr_band,
  input  logic [15:0]        i_wr_gain,
  input  logic               i_sample_valid,
  output logic [N_BANDS-1:0] o_set,
  output logic [15:0]        o_gain,
  output logic               o_next,
  output logic               o_busy,
  output logic [N_BANDS-1:0] o_pending,
  output logic               o_err,
  output logic               o_overrun
);

  localparam int unsigned GAIN_W  = 16;
  localparam int unsigned CNT_MAX = (SET_CYCLES > NEXT_CYCLES) ? SET_CYCLES : NEXT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NEXT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_SET  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAIN_W-1:0]  gain_q [N_BANDS];
  logic [GAIN_W-1:0]  gain_d [N_BANDS];
  logic [N_BANDS-1:0] dirty_d;
  logic [BAND_W-1:0]  rr_q, rr_d;
  logic               pend_q, pend_d;
  logic [N_BANDS-1:0] set_d;
  logic [GAIN_W-1:0]  bus_d;
  logic               next_d, err_d, ovr_d;
  logic [BAND_W-1:0]  pick, idx;
  logic               pick_valid;

  // Round-robin search for the first dirty band starting at rr
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = rr_q;
    for (int unsigned i = 0; i < N_BANDS; i++) begin
      if (!pick_valid && o_pending[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
      idx = (idx == BAND_W'(N_BANDS - 1)) ? '0 : idx + BAND_W'(1);
    end
  end

  // Next-state, staging and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    dirty_d = o_pending;
    rr_d    = rr_q;
    pend_d  = pend_q;
    set_d   = '0;
    bus_d   = o_gain;
    next_d  = o_next;
    err_d   = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_sample_valid || pend_q) begin
          state_d = S_NEXT;
          cnt_d   = '0;
          next_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (pick_valid) begin
          state_d        = S_SET;
          cnt_d          = '0;
          set_d[pick]    = 1'b1;
          bus_d          = gain_q[pick];
          dirty_d[pick]  = 1'b0;
          rr_d           = (pick == BAND_W'(N_BANDS - 1)) ? '0 : pick + BAND_W'(1);
        end
      end
      S_NEXT: begin
        if (cnt_q == CNT_W'(NEXT_CYCLES - 1)) begin
          next_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: state_d = S_IDLE;
      S_SET: begin
        if (cnt_q == CNT_W'(SET_CYCLES - 1)) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A sample arriving while busy is deferred; a second one is dropped
    if (state_q != S_IDLE && i_sample_valid) begin
      ovr_d  = pend_q;
      pend_d = 1'b1;
    end

    // Writes override the launch clear so a same-cycle rewrite stays dirty
    if (i_wr) begin
      if (32'(i_wr_band) < N_BANDS) begin
        gain_d[i_wr_band]  = i_wr_gain;
        dirty_d[i_wr_band] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      for (int i = 0; i < N_BANDS; i++) gain_q[i] <= '0;
      o_pending <= '0;
      rr_q      <= '0;
      pend_q    <= 1'b0;
      o_set     <= '0;
      o_gain    <= '0;
      o_next    <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gain_q    <= gain_d;
      o_pending <= dirty_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
      o_set     <= set_d;
      o_gain    <= bus_d;
      o_next    <= next_d;
      o_busy    <= (state_d != S_IDLE);
      o_err     <= err_d;
      o_overrun <= ovr_d;
    end
  end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: directed scenarios plus random traffic checked
// against a timeline model of update/sample slots.
module tb_eq_band_scheduler;

  localparam int unsigned N_BANDS     = 10;
  localparam int unsigned BAND_W      = 4;
  localparam int unsigned SET_CYCLES  = 4;
  localparam int unsigned NEXT_CYCLES = 2;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_wr;
  logic [BAND_W-1:0]  i_wr_band;
  logic [15:0]        i_wr_gain;
  logic               i_sample_valid;
  logic [N_BANDS-1:0] o_set;
  logic [15:0]        o_gain;
  logic               o_next;
  logic               o_busy;
  logic [N_BANDS-1:0] o_pending;
  logic               o_err;
  logic               o_overrun;

  eq_band_scheduler #(
    .N_BANDS(N_BANDS), .BAND_W(BAND_W), .SET_CYCLES(SET_CYCLES), .NEXT_CYCLES(NEXT_CYCLES)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_wr_band(i_wr_band),
    .i_wr_gain(i_wr_gain), .i_sample_valid(i_sample_valid), .o_set(o_set),
    .o_gain(o_gain), .o_next(o_next), .o_busy(o_busy), .o_pending(o_pending),
    .o_err(o_err), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc;

  // Model: the controller is a resource free from cycle m_free onwards
  logic [15:0] m_gain [N_BANDS];
  bit          m_dirty [N_BANDS];
  int          m_rr, m_free, m_ns, m_ne, m_set_cyc, m_set_band;
  bit          m_pend, m_err, m_ovr;
  logic [15:0] m_gout;

  task automatic model_reset();
    for (int i = 0; i < int'(N_BANDS); i++) begin
      m_gain[i]  = '0;
      m_dirty[i] = 1'b0;
    end
    m_rr = 0; m_free = 0; m_ns = -10; m_ne = -10; m_set_cyc = -10; m_set_band = 0;
    m_pend = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_gout = '0;
  endtask

  task automatic model_step(input bit wr, input int band, input int gain, input bit sv);
    int k;
    int b;
    bit any;
    k = cyc;
    m_err = 1'b0;
    m_ovr = 1'b0;
    any = 1'b0;
    for (int i = 0; i < int'(N_BANDS); i++) any |= m_dirty[i];
    if (k >= m_free) begin
      if (sv || m_pend) begin
        m_ns = k + 1;
        m_ne = k + int'(NEXT_CYCLES);
        m_free = k + int'(NEXT_CYCLES) + 2;
        m_pend = 1'b0;
      end else if (any) begin
        b = -1;
        for (int i = 0; i < int'(N_BANDS); i++)
          if (b < 0 && m_dirty[(m_rr + i) % int'(N_BANDS)]) b = (m_rr + i) % int'(N_BANDS);
        m_set_cyc  = k + 1;
        m_set_band = b;
        m_gout     = m_gain[b];
        m_dirty[b] = 1'b0;
        m_rr       = (b + 1) % int'(N_BANDS);
        m_free     = k + int'(SET_CYCLES) + 1;
      end
    end else if (sv) begin
      m_ovr  = m_pend;
      m_pend = 1'b1;
    end
    if (wr) begin
      if (band < int'(N_BANDS)) begin
        m_gain[band]  = 16'(gain);
        m_dirty[band] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  function automatic logic [N_BANDS-1:0] exp_set();
    logic [N_BANDS-1:0] v;
    v = '0;
    if (cyc == m_set_cyc) v[m_set_band] = 1'b1;
    return v;
  endfunction

  function automatic logic [N_BANDS-1:0] exp_pending();
    logic [N_BANDS-1:0] v;
    for (int i = 0; i < int'(N_BANDS); i++) v[i] = m_dirty[i];
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, then sample #1 after the edge
  task automatic tick(input bit wr, input int band, input int gain, input bit sv);
    i_wr           = wr;
    i_wr_band      = BAND_W'(band);
    i_wr_gain      = 16'(gain);
    i_sample_valid = sv;
    model_step(wr, band, gain, sv);
    @(posedge i_clk);
    #1;
    cyc++;
    i_wr           = 1'b0;
    i_sample_valid = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_wr = 1'b0; i_wr_band = '0; i_wr_gain = '0; i_sample_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_set, o_gain, o_next, o_busy, o_err, o_overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: set=%h gain=%h next=%b busy=%b err=%b ovr=%b, all must be 0",
               o_set, o_gain, o_next, o_busy, o_err, o_overrun);
    end
    total++;
    if (o_pending !== '0) begin
      bad++;
      $display("FAIL reset_pending: got %h want 0", o_pending);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    tick(1'b1, 3, 6, 1'b0);
    total++;
    if (o_set !== '0 || o_pending !== 10'h008) begin
      bad++;
      $display("FAIL single_t1: set=%h pending=%h want set=0 pending=008", o_set, o_pending);
    end
    idle();
    total++;
    if (o_set !== 10'h008 || o_gain !== 16'd6 || o_pending !== '0) begin
      bad++;
      $display("FAIL single_t2: set=%h gain=%h pending=%h want 008/0006/000", o_set, o_gain, o_pending);
    end
    for (int i = 3; i <= 5; i++) begin
      idle();
      total++;
      if (o_set !== '0 || o_gain !== 16'd6 || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL single_hold t%0d: set=%h gain=%h busy=%b want 000/0006/1", i, o_set, o_gain, o_busy);
      end
    end
    idle();
    total++;
    if (o_busy !== 1'b0 || o_gain !== 16'd6) begin
      bad++;
      $display("FAIL single_t6: busy=%b gain=%h want 0/0006", o_busy, o_gain);
    end
  endtask

  task automatic test_burst_order();
    int n;
    int at [3];
    logic [N_BANDS-1:0] s [3];
    logic [15:0] g [3];
    int want_at [3] = '{5, 10, 15};
    logic [N_BANDS-1:0] want_s [3] = '{10'h004, 10'h080, 10'h200};
    logic [15:0] want_g [3] = '{16'h0022, 16'h0011, 16'h0099};
    do_reset();
    n = 0;
    tick(1'b0, 0, 0, 1'b1);
    tick(1'b1, 7, 'h11, 1'b0);
    tick(1'b1, 2, 'h22, 1'b0);
    tick(1'b1, 9, 'h99, 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle();
      if (o_set !== '0 && n < 3) begin
        at[n] = cyc; s[n] = o_set; g[n] = o_gain; n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL burst_count: got %0d set pulses want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (at[i] != want_at[i] || s[i] !== want_s[i] || g[i] !== want_g[i]) begin
          bad++;
          $display("FAIL burst_%0d: cyc=%0d set=%h gain=%h want cyc=%0d set=%h gain=%h",
                   i, at[i], s[i], g[i], want_at[i], want_s[i], want_g[i]);
        end
      end
    end
  endtask

  task automatic test_sample_during_set();
    do_reset();
    tick(1'b1, 5, 'h55, 1'b0);
    idle();
    total++;
    if (o_set !== 10'h020) begin
      bad++;
      $display("FAIL defer_set: got %h want 020", o_set);
    end
    tick(1'b0, 0, 0, 1'b1);
    for (int c = 4; c <= 10; c++) begin
      idle();
      total++;
      if (o_next !== ((c == 7 || c == 8) ? 1'b1 : 1'b0) || o_set !== '0) begin
        bad++;
        $display("FAIL defer_next c%0d: next=%b set=%h want next=%b set=0", c, o_next, o_set,
                 (c == 7 || c == 8));
      end
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL defer_busy_end: got %b want 0", o_busy);
    end
  endtask

  task automatic test_double_sample();
    int ovr_n;
    int next_n;
    do_reset();
    tick(1'b1, 5, 'h55, 1'b0);
    idle();
    tick(1'b0, 0, 0, 1'b1);
    ovr_n = 0; next_n = 0;
    tick(1'b0, 0, 0, 1'b1);
    total++;
    if (o_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_pulse: got %b want 1", o_overrun);
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      ovr_n += int'(o_overrun);
      next_n += int'(o_next);
    end
    total++;
    if (ovr_n != 0 || next_n != int'(NEXT_CYCLES)) begin
      bad++;
      $display("FAIL overrun_single: extra_ovr=%0d next_cycles=%0d want 0/%0d", ovr_n, next_n, NEXT_CYCLES);
    end
  endtask

  task automatic test_write_during_launch();
    do_reset();
    tick(1'b1, 4, 3, 1'b0);
    tick(1'b1, 4, -12, 1'b0);
    total++;
    if (o_set !== 10'h010 || o_gain !== 16'd3 || o_pending !== 10'h010) begin
      bad++;
      $display("FAIL collide_first: set=%h gain=%h pending=%h want 010/0003/010", o_set, o_gain, o_pending);
    end
    for (int c = 3; c <= 6; c++) begin
      idle();
      total++;
      if (o_set !== '0) begin
        bad++;
        $display("FAIL collide_quiet c%0d: set=%h want 0", c, o_set);
      end
    end
    idle();
    total++;
    if (o_set !== 10'h010 || o_gain !== 16'hFFF4 || o_pending !== '0) begin
      bad++;
      $display("FAIL collide_second: set=%h gain=%h pending=%h want 010/fff4/000", o_set, o_gain, o_pending);
    end
  endtask

  task automatic test_bad_band();
    do_reset();
    tick(1'b1, 12, 'h7, 1'b0);
    total++;
    if (o_err !== 1'b1 || o_pending !== '0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_band: err=%b pending=%h busy=%b want 1/000/0", o_err, o_pending, o_busy);
    end
    idle();
    total++;
    if (o_err !== 1'b0 || o_set !== '0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_band_after: err=%b set=%h busy=%b want 0/000/0", o_err, o_set, o_busy);
    end
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    tick(1'b1, 1, 'h40, 1'b0);
    idle();
    tick(1'b1, 6, 5, 1'b0);
    total++;
    if (o_busy !== 1'b1 || o_gain !== 16'h0040 || o_pending !== 10'h040) begin
      bad++;
      $display("FAIL midset_pre: busy=%b gain=%h pending=%h want 1/0040/040", o_busy, o_gain, o_pending);
    end
    #2 i_rst = 1'b1;
    #1;
    total++;
    if ({o_set, o_gain, o_next, o_busy, o_pending, o_err, o_overrun} !== '0) begin
      bad++;
      $display("FAIL midset_async: set=%h gain=%h next=%b busy=%b pending=%h, all must be 0",
               o_set, o_gain, o_next, o_busy, o_pending);
    end
    do_reset();
    idle();
    total++;
    if (o_set !== '0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL midset_after: set=%h busy=%b want 0/0", o_set, o_busy);
    end
  endtask

  task automatic test_random();
    bit wr;
    bit sv;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 9) == 0);
      tick(wr, int'($urandom_range(0, 11)), int'($urandom_range(0, 65535)), sv);
      total++;
      if (o_set !== exp_set() || o_gain !== m_gout) begin
        bad++;
        $display("FAIL rand_set c%0d: set=%h gain=%h want %h/%h", cyc, o_set, o_gain, exp_set(), m_gout);
      end
      total++;
      if (o_next !== (cyc >= m_ns && cyc <= m_ne) || o_busy !== (cyc < m_free)) begin
        bad++;
        $display("FAIL rand_next c%0d: next=%b busy=%b want %b/%b", cyc, o_next, o_busy,
                 (cyc >= m_ns && cyc <= m_ne), (cyc < m_free));
      end
      total++;
      if (o_pending !== exp_pending() || o_err !== m_err || o_overrun !== m_ovr) begin
        bad++;
        $display("FAIL rand_flags c%0d: pending=%h err=%b ovr=%b want %h/%b/%b", cyc, o_pending,
                 o_err, o_overrun, exp_pending(), m_err, m_ovr);
      end
      total++;
      if ((o_set !== '0 && o_next) || $countones(o_set) > 1) begin
        bad++;
        $display("FAIL rand_invariant c%0d: set=%h next=%b", cyc, o_set, o_next);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_order();
    test_sample_during_set();
    test_double_sample();
    test_write_during_launch();
    test_bad_band();
    test_reset_mid_set();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eq_band_scheduler.md
Name: eq_band_scheduler

Overview:
- Controller for a bank of N_BANDS peaking-biquad sections forming the graphic equaliser.
- Stages per-band gain writes from the UI/control path.
- Serialises coefficient updates onto a shared gain bus with one-hot set pulses.
- Generates the broadcast sample-advance strobe (next) for every incoming audio sample; a coefficient update is never overlapped with a sample advance.

Parameters:
N_BANDS, 10, number of biquad bands driven
BAND_W, 4, width of band index (>= clog2(N_BANDS))
SET_CYCLES, 4, cycles one band update occupies (set pulse + 3 compute cycles), min 4
NEXT_CYCLES, 2, cycles o_next is held high per sample, min 1

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_wr  in  1  gain write strobe, one cycle per write
i_wr_band  in  BAND_W  band index of write
i_wr_gain  in  16  signed integer gain in dB for that band
i_sample_valid  in  1  one-cycle pulse: new audio sample present on datapath
o_set  out  N_BANDS  one-hot set pulse to the biquad of each band
o_gain  out  16  shared gain bus to all biquads
o_next  out  1  broadcast sample-advance strobe to all biquads
o_busy  out  1  high whenever FSM not in S_IDLE
o_pending  out  N_BANDS  dirty flags: staged gain not yet applied
o_err  out  1  one-cycle pulse: write with i_wr_band >= N_BANDS (write dropped)
o_overrun  out  1  one-cycle pulse: sample arrived while one already pending (dropped)

Behaviour:
- Reset (async, any state, mid-update included):
  - State S_IDLE.
  - o_set=0, o_gain=0, o_next=0, o_busy=0, o_err=0, o_overrun=0.
  - All staged gains=0, o_pending=0, sample_pend=0, round-robin pointer rr=0.
  - Biquads share the reset and default to 0 dB, so nothing is dirty.
- Staging:
  - i_wr with valid band b: gain[b] <= i_wr_gain, dirty[b] <= 1, visible the next cycle. Latest write wins.
  - Writes are accepted in every state; there is no backpressure.
- Sample pending:
  - i_sample_valid sets sample_pend unless it is consumed the same cycle (IDLE launch).
  - i_sample_valid while sample_pend=1 and not consumed: o_overrun pulses next cycle; the extra sample is dropped.
- FSM states: S_IDLE, S_NEXT, S_GAP, S_SET.
  - S_IDLE, priority 1, sample: if i_sample_valid or sample_pend, go to S_NEXT, o_next<=1, clear sample_pend.
  - S_IDLE, priority 2, band update: if any dirty, pick the first dirty band searching rr, rr+1, ... wrapping mod N_BANDS. Then o_gain<=gain[b], o_set[b]<=1, clear dirty[b], rr<=b+1 mod N_BANDS, go to S_SET.
  - S_NEXT: o_next high exactly NEXT_CYCLES cycles, then o_next<=0 and go to S_GAP.
  - S_GAP: one cycle with o_next low, so biquads latch the sample on their falling-edge handling; then S_IDLE.
  - S_SET: o_set high only in the first cycle. o_gain stays stable for all SET_CYCLES cycles, then S_IDLE (o_gain keeps its value).
- Simultaneous events:
  - Write to band b in the same cycle b is launched: o_gain takes the old staged value; dirty[b] stays 1 with the new value; a second update follows later.
  - Sample arrival during S_SET/S_NEXT/S_GAP: deferred via sample_pend and served first on return to S_IDLE.
  - Sample and dirty bands together in S_IDLE: the sample wins.
- Latency:
  - i_sample_valid at cycle t in S_IDLE: o_next high in cycles t+1 .. t+NEXT_CYCLES.
  - Write at t, controller idle, no sample: o_set pulse at t+2.
  - Back-to-back updates are spaced SET_CYCLES+1 cycles (the S_IDLE cycle included).
- Invariants:
  - o_set is never asserted while o_next is high or in S_GAP.
  - At most one o_set bit is high at a time.

Test Plan:
- Reset, then write band 3 gain=+6 at t → o_set=0x008 at t+2 only, o_gain=6 for 4 cycles, o_pending[3] clears, o_busy low at t+6.
- Writes to bands 7, 2, 9 in one burst, rr=0 → update order 2, 7, 9; o_set pulses spaced 5 cycles; o_gain=respective values.
- i_sample_valid during S_SET of band 5 → o_next deferred until after S_SET ends, high 2 cycles, then one low gap cycle; no o_set during that window.
- Two i_sample_valid during one S_SET → one o_next burst, o_overrun single pulse.
- Write band 4 gain=-12 in the same cycle band 4 launches with old gain 3 → o_gain=3 now; second o_set[4] later with o_gain=-12 (0xFFF4).
- i_wr_band=12 → o_err pulse, no state change. Assert i_rst mid-S_SET → all outputs 0 immediately, o_pending=0.
